route_allocator: RTL and testbench
==================================

ROUTE_ALLOCATOR -- requirements
Module: route_allocator

Interface
REQ-001 Parameter N, default 4: number of switch input ports and output ports.
REQ-002 Parameter REQUEST_WIDTH, default 2: width of one output-port index; SHALL be at least clog2(N).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 routeReserveRequestValid  input  N  bit i: input port i requests an output.
REQ-006 routeReserveRequest  input  N*REQUEST_WIDTH  slice i (bits i*REQUEST_WIDTH +: REQUEST_WIDTH): output index requested by input i.
REQ-007 routeRelieve  input  N  bit i: input i releases the output it holds (tail flit done).
REQ-008 routeReserveStatus  output  N  bit i: input i currently owns an output.
REQ-009 outBusy  output  N  bit j: output j is reserved.
REQ-010 outSelect  output  N*REQUEST_WIDTH  slice j: index of the input owning output j; crossbar select.

Function
REQ-011 The block SHALL hold, per output j, a busy bit and an owner index; per input i, a held bit and the held output index.
REQ-012 An input SHALL be eligible for output j when its request valid is 1, its request equals j, it holds no output, and its relieve bit is 0.
REQ-013 Requests with index >= N SHALL be ignored (no grant, no state change).
REQ-014 Each output not busy at the start of a cycle SHALL grant at most one eligible input per cycle, chosen by round-robin.
REQ-015 Round-robin: per-output pointer p_j; the first eligible input searched in order p_j, p_j+1, ... mod N wins.
REQ-016 On a grant to input k, p_j SHALL become (k+1) mod N; otherwise p_j SHALL be unchanged.
REQ-017 Grant latency: eligible request in cycle t -> routeReserveStatus[k], outBusy[j], outSelect[j]=k all visible from cycle t+1, registered outputs.
REQ-018 The allocator SHALL NOT latch requests; an input that loses arbitration SHALL keep routeReserveRequestValid asserted and is re-arbitrated each cycle.
REQ-019 routeReserveStatus[i] SHALL remain 1 while i holds an output, regardless of its request inputs.
REQ-020 routeRelieve[i]=1 while i holds output j SHALL clear held[i], busy[j] from cycle t+1; outSelect[j] SHALL retain its last value.
REQ-021 A released output SHALL NOT be granted in the same cycle as its relieve; it is grantable from cycle t+1.
REQ-022 routeRelieve[i] while i holds nothing SHALL be ignored.
REQ-023 A request from an input already holding an output SHALL be ignored; no second reservation.
REQ-024 Simultaneous requests for different free outputs SHALL all be granted in the same cycle.
REQ-025 No two outputs SHALL have the same owner; no input SHALL hold more than one output.

Reset
REQ-026 While rst=0, asynchronously: all busy and held bits 0, all owner/held indices 0, all pointers 0, so routeReserveStatus=0, outBusy=0, outSelect=0.
REQ-027 Reset asserted mid-packet SHALL drop every reservation; after release, the first grant SHALL follow pointers at 0.
REQ-028 No grant SHALL occur in the first rising edge while rst=0.

Verification
REQ-029 After reset, input 1 requests output 3 at cycle 0 -> cycle 1: routeReserveStatus=0010, outBusy=1000, outSelect[3]=1.
REQ-030 Inputs 0,2,3 request output 1 simultaneously, pointer 0 -> input 0 granted; relieve 0 -> next grant input 2, then input 3 (pointers 1 then 3 then 0).
REQ-031 Input 0 holds output 2; input 1 requests 2 -> status[1]=0 until cycle after routeRelieve[0]; input 1 granted exactly one cycle after busy[2] drops.
REQ-032 Inputs 0..3 request outputs 3,2,1,0 in one cycle -> cycle+1: routeReserveStatus=1111, outSelect = {0,1,2,3} for outputs {3,2,1,0}.
REQ-033 Input 2 asserts routeRelieve with no reservation and requests while holding -> no change to any output.
REQ-034 rst pulsed low while all four outputs busy -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/route_allocator.sv
// route_allocator: per-output round-robin reservation of a switch crossbar.
// Each output grants at most one requesting input per cycle; a reservation
// is held until the owning input relieves it. The owner index of every
// output drives the crossbar select directly from registers.
// REQUEST_WIDTH must be at least clog2(N).
module route_allocator #(
    parameter int N             = 4,
    parameter int REQUEST_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               routeReserveRequestValid,
    input  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic [N-1:0]               routeRelieve,
    output logic [N-1:0]               routeReserveStatus,
    output logic [N-1:0]               outBusy,
    output logic [N*REQUEST_WIDTH-1:0] outSelect
);

    typedef logic [REQUEST_WIDTH-1:0] idx_t;

    // Per-output state: busy flag, owning input, round-robin pointer.
    logic [N-1:0] busy_q, busy_d;
    idx_t         owner_q [N];
    idx_t         owner_d [N];
    idx_t         ptr_q   [N];
    idx_t         ptr_d   [N];

    // Per-input state: holds-an-output flag and the index of that output.
    logic [N-1:0] held_q, held_d;
    idx_t         held_idx_q [N];
    idx_t         held_idx_d [N];

    // elig[j][i]: input i competes for output j this cycle.
    logic [N-1:0] elig [N];
    logic [N-1:0] gnt_vld;
    idx_t         gnt_idx [N];

    // Extract the requested output index of input i from the packed bus.
    function automatic idx_t req_of(input logic [N*REQUEST_WIDTH-1:0] bus, input int i);
        return bus[i*REQUEST_WIDTH +: REQUEST_WIDTH];
    endfunction

    // Round-robin pick among cand starting at ptr; returns {found, winner}.
    // The doubled vector shifted by ptr puts the search start at bit 0.
    function automatic logic [REQUEST_WIDTH:0] rr_pick(input logic [N-1:0] cand, input idx_t ptr);
        logic [2*N-1:0] dbl;
        logic           found;
        idx_t           win;
        int             k;
        dbl   = {cand, cand} >> ptr;
        found = 1'b0;
        win   = '0;
        for (int off = 0; off < N; off++) begin
            if (!found && dbl[off]) begin
                found = 1'b1;
                k     = int'(ptr) + off;
                if (k >= N) k = k - N;
                win   = idx_t'(k);
            end
        end
        return {found, win};
    endfunction

    // Eligibility matrix: valid, in-range request, not holding, not relieving.
    always_comb begin
        idx_t r;
        for (int j = 0; j < N; j++) elig[j] = '0;
        for (int i = 0; i < N; i++) begin
            r = req_of(routeReserveRequest, i);
            for (int j = 0; j < N; j++) begin
                if (routeReserveRequestValid[i] && !held_q[i] && !routeRelieve[i]
                    && (int'(r) < N) && (r == idx_t'(j))) begin
                    elig[j][i] = 1'b1;
                end
            end
        end
    end

    // Arbitration: only outputs free at the start of the cycle may grant, so
    // an output relieved this cycle cannot be re-granted until the next one.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            gnt_vld[j] = 1'b0;
            gnt_idx[j] = '0;
            if (!busy_q[j]) begin
                {gnt_vld[j], gnt_idx[j]} = rr_pick(elig[j], ptr_q[j]);
            end
        end
    end

    // Next-state: apply relieves, then grants; owner index is kept on relieve.
    always_comb begin
        int nxt;
        busy_d     = busy_q;
        held_d     = held_q;
        owner_d    = owner_q;
        held_idx_d = held_idx_q;
        ptr_d      = ptr_q;
        nxt        = 0;

        for (int i = 0; i < N; i++) begin
            if (routeRelieve[i] && held_q[i]) begin
                held_d[i] = 1'b0;
                for (int j = 0; j < N; j++) begin
                    if (held_idx_q[i] == idx_t'(j)) busy_d[j] = 1'b0;
                end
            end
        end

        for (int j = 0; j < N; j++) begin
            if (gnt_vld[j]) begin
                busy_d[j]  = 1'b1;
                owner_d[j] = gnt_idx[j];
                nxt        = int'(gnt_idx[j]) + 1;
                if (nxt >= N) nxt = 0;
                ptr_d[j]   = idx_t'(nxt);
                for (int i = 0; i < N; i++) begin
                    if (gnt_idx[j] == idx_t'(i)) begin
                        held_d[i]     = 1'b1;
                        held_idx_d[i] = idx_t'(j);
                    end
                end
            end
        end
    end

    // State registers; reset drops every reservation and rewinds pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            held_q <= '0;
            for (int j = 0; j < N; j++) begin
                owner_q[j]    <= '0;
                ptr_q[j]      <= '0;
                held_idx_q[j] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            held_q     <= held_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            held_idx_q <= held_idx_d;
        end
    end

    // Outputs come straight from the state registers.
    always_comb begin
        outSelect = '0;
        for (int j = 0; j < N; j++) begin
            outSelect[j*REQUEST_WIDTH +: REQUEST_WIDTH] = owner_q[j];
        end
    end

    assign routeReserveStatus = held_q;
    assign outBusy            = busy_q;

endmodule

// File: tb/tb_route_allocator.sv
// Testbench for route_allocator: directed vector table, reset corner cases,
// and a randomized run against a reference model, all through a scoreboard.
module tb_route_allocator;

    localparam int N  = 4;
    localparam int RW = 3;  // wider than needed so out-of-range requests exist

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      vld, rel, st, busy;
    logic [N*RW-1:0]   req, sel;

    always #5 clk = ~clk;

    route_allocator #(.N(N), .REQUEST_WIDTH(RW)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .routeReserveRequestValid (vld),
        .routeReserveRequest      (req),
        .routeRelieve             (rel),
        .routeReserveStatus       (st),
        .outBusy                  (busy),
        .outSelect                (sel)
    );

    typedef struct {
        logic [3:0]  st;
        logic [3:0]  busy;
        logic [11:0] sel;
        int          id;
    } exp_t;

    typedef struct {
        logic [3:0]  vld;
        logic [11:0] req;
        logic [3:0]  rel;
        logic [3:0]  st;
        logic [3:0]  busy;
        logic [11:0] sel;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[20];
    int   total = 0;
    int   bad   = 0;

    // reference model state
    logic [3:0] m_busy, m_held;
    int         m_owner[4], m_hidx[4], m_ptr[4];

    function automatic logic [11:0] pk(input int a3, input int a2, input int a1, input int a0);
        return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [11:0] r, input logic [3:0] l,
                                input logic [3:0] s, input logic [3:0] b, input logic [11:0] o);
        vec_t x;
        x.vld = v; x.req = r; x.rel = l; x.st = s; x.busy = b; x.sel = o;
        return x;
    endfunction

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s id=%0d got=%h want=%h", nm, id, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [11:0] r, input logic [3:0] l, input exp_t e);
        @(negedge clk);
        vld = v; req = r; rel = l;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: one expectation per rising edge, sampled after it.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("status", e.id, 32'(st),   32'(e.st));
            check("busy",   e.id, 32'(busy), 32'(e.busy));
            check("select", e.id, 32'(sel),  32'(e.sel));
        end
    end

    task automatic model_reset();
        m_busy = '0; m_held = '0;
        for (int i = 0; i < 4; i++) begin
            m_owner[i] = 0; m_hidx[i] = 0; m_ptr[i] = 0;
        end
    endtask

    task automatic model_step(input logic [3:0] v, input logic [11:0] r, input logic [3:0] l,
                              input int id, output exp_t e);
        logic [3:0] nb, nh;
        logic       done;
        int         want;
        nb = m_busy; nh = m_held;
        for (int i = 0; i < 4; i++)
            if (l[i] && m_held[i])
                for (int j = 0; j < 4; j++)
                    if (m_hidx[i] == j) begin nh[i] = 1'b0; nb[j] = 1'b0; end
        for (int j = 0; j < 4; j++) begin
            if (!m_busy[j]) begin
                done = 1'b0;
                for (int off = 0; off < 4; off++) begin
                    for (int c = 0; c < 4; c++) begin
                        want = int'(r[c*RW +: RW]);
                        if (!done && c == (m_ptr[j] + off) % 4 && v[c] && !m_held[c]
                            && !l[c] && want == j) begin
                            done       = 1'b1;
                            nb[j]      = 1'b1;
                            nh[c]      = 1'b1;
                            m_owner[j] = c;
                            m_hidx[c]  = j;
                            m_ptr[j]   = (c + 1) % 4;
                        end
                    end
                end
            end
        end
        m_busy = nb; m_held = nh;
        e.st   = m_held;
        e.busy = m_busy;
        e.sel  = pk(m_owner[3], m_owner[2], m_owner[1], m_owner[0]);
        e.id   = id;
    endtask

    initial begin
        exp_t        e;
        logic [3:0]  rv, rl;
        logic [11:0] rr;

        rst = 1'b0; vld = '0; req = '0; rel = '0;

        //           vld      req            rel      status   busy     select
        tbl[0]  = mk(4'b0010, pk(0,0,3,0),   4'b0000, 4'b0010, 4'b1000, pk(1,0,0,0));
        tbl[1]  = mk(4'b0010, pk(0,0,3,0),   4'b0100, 4'b0010, 4'b1000, pk(1,0,0,0));
        tbl[2]  = mk(4'b0000, pk(0,0,0,0),   4'b0010, 4'b0000, 4'b0000, pk(1,0,0,0));
        tbl[3]  = mk(4'b1101, pk(1,1,0,1),   4'b0000, 4'b0001, 4'b0010, pk(1,0,0,0));
        tbl[4]  = mk(4'b1100, pk(1,1,0,1),   4'b0001, 4'b0000, 4'b0000, pk(1,0,0,0));
        tbl[5]  = mk(4'b1100, pk(1,1,0,0),   4'b0000, 4'b0100, 4'b0010, pk(1,0,2,0));
        tbl[6]  = mk(4'b1000, pk(1,0,0,0),   4'b0100, 4'b0000, 4'b0000, pk(1,0,2,0));
        tbl[7]  = mk(4'b1000, pk(1,0,0,0),   4'b0000, 4'b1000, 4'b0010, pk(1,0,3,0));
        tbl[8]  = mk(4'b0000, pk(0,0,0,0),   4'b1000, 4'b0000, 4'b0000, pk(1,0,3,0));
        tbl[9]  = mk(4'b0100, pk(0,0,0,0),   4'b0100, 4'b0000, 4'b0000, pk(1,0,3,0));
        tbl[10] = mk(4'b0001, pk(0,0,0,5),   4'b0000, 4'b0000, 4'b0000, pk(1,0,3,0));
        tbl[11] = mk(4'b0001, pk(0,0,0,7),   4'b0000, 4'b0000, 4'b0000, pk(1,0,3,0));
        tbl[12] = mk(4'b1111, pk(0,1,2,3),   4'b0000, 4'b1111, 4'b1111, pk(0,1,2,3));
        tbl[13] = mk(4'b0000, pk(0,0,0,0),   4'b1111, 4'b0000, 4'b0000, pk(0,1,2,3));
        tbl[14] = mk(4'b0001, pk(0,0,0,2),   4'b0000, 4'b0001, 4'b0100, pk(0,0,2,3));
        tbl[15] = mk(4'b0010, pk(0,0,2,0),   4'b0000, 4'b0001, 4'b0100, pk(0,0,2,3));
        tbl[16] = mk(4'b0010, pk(0,0,2,0),   4'b0000, 4'b0001, 4'b0100, pk(0,0,2,3));
        tbl[17] = mk(4'b0010, pk(0,0,2,0),   4'b0001, 4'b0000, 4'b0000, pk(0,0,2,3));
        tbl[18] = mk(4'b0010, pk(0,0,2,0),   4'b0000, 4'b0010, 4'b0100, pk(0,1,2,3));
        tbl[19] = mk(4'b0000, pk(0,0,0,0),   4'b0010, 4'b0000, 4'b0000, pk(0,1,2,3));

        // reset state, and no grant on an edge while reset is held
        #2;
        check("rst_status", 0, 32'(st),   32'h0);
        check("rst_busy",   0, 32'(busy), 32'h0);
        check("rst_select", 0, 32'(sel),  32'h0);
        vld = 4'b1111; req = pk(0,1,2,3);
        @(posedge clk); #1;
        check("rst_edge_status", 1, 32'(st),   32'h0);
        check("rst_edge_busy",   1, 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1; vld = '0; req = '0;

        for (int t = 0; t < 20; t++) begin
            e.st = tbl[t].st; e.busy = tbl[t].busy; e.sel = tbl[t].sel; e.id = 10 + t;
            drive(tbl[t].vld, tbl[t].req, tbl[t].rel, e);
        end

        // all outputs busy, then asynchronous reset mid-cycle
        e.st = 4'b1111; e.busy = 4'b1111; e.sel = pk(0,1,2,3); e.id = 100;
        drive(4'b1111, pk(0,1,2,3), 4'b0000, e);
        @(negedge clk);
        vld = '0; req = '0;
        rst = 1'b0;
        #1;
        check("async_status", 101, 32'(st),   32'h0);
        check("async_busy",   101, 32'(busy), 32'h0);
        check("async_select", 101, 32'(sel),  32'h0);
        vld = 4'b1010; req = pk(1,0,1,0);
        @(posedge clk); #1;
        check("held_rst_status", 102, 32'(st),   32'h0);
        check("held_rst_busy",   102, 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        // pointer for output 1 is back at 0, so input 1 beats input 3
        check("post_rst_status", 103, 32'(st),   32'h2);
        check("post_rst_busy",   103, 32'(busy), 32'h2);
        check("post_rst_select", 103, 32'(sel),  32'(pk(0,0,1,0)));
        e.st = 4'b0000; e.busy = 4'b0000; e.sel = pk(0,0,1,0); e.id = 104;
        drive(4'b0000, pk(0,0,0,0), 4'b0010, e);

        // randomized traffic against the reference model
        @(negedge clk);
        rst = 1'b0; vld = '0; req = '0; rel = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 400; t++) begin
            rv = 4'($urandom_range(0, 15));
            rr = 12'($urandom);
            rl = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            model_step(rv, rr, rl, 1000 + t, e);
            drive(rv, rr, rl, e);
        end

        repeat (3) @(negedge clk);
        check("drain", 9999, 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
